// File: rtl/key_request_arbiter_pkg.sv
// rtl/key_request_arbiter_pkg.sv - shared types and round-robin pick helper for the key request arbiter
//
// Purpose: FSM state type and the round-robin selection function used by
//          key_request_arbiter.
// Contents:
//   state_t  - IDLE (nothing offered) / OFFER (grant presented, waiting for ready)
//   MAX_N    - widest requester vector rr_pick accepts
//   rr_pick  - first set bit of pend, scanning from (last+1) mod n upward with wrap

package key_arb_pkg;

  typedef enum logic {IDLE, OFFER} state_t;

  localparam int MAX_N = 32;

  // Callers zero-extend their pending vector to MAX_N bits and pass their
  // own requester count in n; the result is truncated to the caller's IDW.
  // When nothing is pending the function returns 0; callers only use the
  // result when at least one bit is set.
  function automatic int rr_pick(input logic [MAX_N-1:0] pend, input int last, input int n);
    int  idx;
    int  pick;
    bit  found;
    pick  = 0;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      if (!found && k <= n) begin
        idx = last + k;
        if (idx >= n) idx = idx - n;
        if (pend[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/key_request_arbiter_if.sv
// rtl/key_request_arbiter_if.sv - valid/ready grant handshake between arbiter and consumer
//
// Purpose: carries one grant offer from the arbiter to the shared consumer.
// Signals:
//   grant_valid  arbiter -> consumer  an offer is presented on grant_id
//   grant_id     arbiter -> consumer  index of the granted key, stable while grant_valid=1
//   grant_ready  consumer -> arbiter  consumer accepts the current offer this cycle
// Modports: master = arbiter side, slave = consumer side.

interface key_request_arbiter_if #(
  parameter int IDW = 2
);

  logic           grant_valid;
  logic [IDW-1:0] grant_id;
  logic           grant_ready;

  modport master (
    output grant_valid,
    output grant_id,
    input  grant_ready
  );

  modport slave (
    input  grant_valid,
    input  grant_id,
    output grant_ready
  );

endinterface

// File: rtl/key_request_arbiter_edge.sv
// rtl/key_request_arbiter_edge.sv - per-key rising-edge detector
//
// Purpose: turns N key levels into one-cycle edge strobes.
// Ports:
//   clk       in   1  system clock
//   reset     in   1  synchronous, active-low
//   key_in    in   N  key levels, already synchronized to clk
//   key_edge  out  N  1 for the cycle a key goes from 0 to 1

module key_edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_edge
);

  logic [N-1:0] key_q;

  // key_q clears on reset so a key held through reset release still
  // produces exactly one edge afterwards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      key_q <= '0;
    end else begin
      key_q <= key_in;
    end
  end

  assign key_edge = key_in & ~key_q;

endmodule

// File: rtl/key_request_arbiter.sv
// rtl/key_request_arbiter.sv - one-shot key requests shared round-robin over a valid/ready grant
//
// Purpose: edge-detects N keys, queues one pending request per key and
//          offers them one at a time to a single consumer, round-robin.
// Ports:
//   clk      in      1   system clock
//   reset    in      1   synchronous, active-low
//   key_in   in      N   key levels, already synchronized to clk
//   grant    master  -   grant_valid / grant_id / grant_ready handshake
//   pending  out     N   per-key queued-request flags (registered)
//   dropped  out     1   1-cycle pulse: an edge arrived on a key already pending

module key_request_arbiter
  import key_arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          key_in,
  key_request_arbiter_if.master grant,
  output logic [N-1:0]          pending,
  output logic                  dropped
);

  state_t         state;
  logic [IDW-1:0] last;
  logic           grant_valid_r;
  logic [IDW-1:0] grant_id_r;
  logic [N-1:0]   key_edge;
  logic [N-1:0]   clr;

  key_edge_detect #(.N(N)) u_edge (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .key_edge (key_edge)
  );

  // One-hot clear for the key whose offer is being accepted this cycle.
  always_comb begin
    clr = '0;
    if (grant_valid_r && grant.grant_ready) begin
      clr[grant_id_r] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending       <= '0;
      dropped       <= 1'b0;
      state         <= IDLE;
      last          <= IDW'(N - 1);
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
    end else begin
      // A fresh edge wins over a same-cycle clear, so a re-press that
      // lands on the handshake cycle is kept as a new request.
      pending <= key_edge | (pending & ~clr);
      dropped <= |(key_edge & pending & ~clr);

      case (state)
        IDLE: begin
          if (|pending) begin
            grant_id_r    <= IDW'(rr_pick(MAX_N'(pending), int'(last), N));
            grant_valid_r <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          // Offer is held indefinitely until the consumer accepts it.
          if (grant.grant_ready) begin
            grant_valid_r <= 1'b0;
            last          <= grant_id_r;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          grant_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign grant.grant_valid = grant_valid_r;
  assign grant.grant_id    = grant_id_r;

endmodule

// File: tb/tb_key_request_arbiter.sv
// tb/tb_key_request_arbiter.sv - directed self-checking bench for key_request_arbiter

module tb_key_request_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic         clk;
  logic         reset;
  logic [N-1:0] key_in;
  logic [N-1:0] pending;
  logic         dropped;

  key_request_arbiter_if #(.IDW(IDW)) bus ();

  key_request_arbiter #(.N(N)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_in  (key_in),
    .grant   (bus.master),
    .pending (pending),
    .dropped (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int drop_cnt = 0;
  int grants[$];
  int gcyc[$];

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gnt(input int i);
    if (i < grants.size()) return grants[i];
    return -1;
  endfunction

  function automatic int gap(input int i);
    if (i + 1 < gcyc.size()) return gcyc[i+1] - gcyc[i];
    return -1;
  endfunction

  // Records handshakes and dropped pulses seen before the edge, then
  // advances one clock and leaves the bench 1 time unit after it.
  task automatic tick();
    if (bus.grant_valid && bus.grant_ready) begin
      grants.push_back(int'(bus.grant_id));
      gcyc.push_back(cyc);
    end
    if (dropped) drop_cnt++;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    reset           = 1'b0;
    key_in          = '0;
    bus.grant_ready = 1'b1;

    // 1: key held through reset -> exactly one grant of id 0
    key_in = 4'b0001;
    tick();
    tick();
    check("rst_valid", int'(bus.grant_valid), 0);
    check("rst_id", int'(bus.grant_id), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_dropped", int'(dropped), 0);
    check("rst_last", int'(dut.last), 3);
    reset = 1'b1;
    grants.delete();
    tick();
    check("t1_pending_set", int'(pending), 1);
    check("t1_valid_lat", int'(bus.grant_valid), 0);
    tick();
    check("t1_valid", int'(bus.grant_valid), 1);
    check("t1_id", int'(bus.grant_id), 0);
    tick();
    check("t1_valid_drop", int'(bus.grant_valid), 0);
    check("t1_pending_clr", int'(pending), 0);
    repeat (6) tick();
    check("t1_ngrants", grants.size(), 1);
    check("t1_gid", gnt(0), 0);

    // 2: all keys in one cycle -> 0,1,2,3 two cycles apart
    reset  = 1'b0;
    key_in = '0;
    tick();
    tick();
    reset = 1'b1;
    grants.delete();
    gcyc.delete();
    drop_cnt = 0;
    key_in = 4'b1111;
    tick();
    check("t2_pending_all", int'(pending), 15);
    repeat (10) tick();
    check("t2_ngrants", grants.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_order", gnt(i), i);
    for (int i = 0; i < 3; i++) check("t2_gap", gap(i), 2);
    check("t2_pending_end", int'(pending), 0);
    check("t2_dropped", drop_cnt, 0);
    key_in = '0;
    tick();
    tick();

    // 3: consumer stalls 5 cycles on an offer of id 2
    bus.grant_ready = 1'b0;
    grants.delete();
    key_in = 4'b0100;
    tick();
    tick();
    check("t3_valid", int'(bus.grant_valid), 1);
    check("t3_id", int'(bus.grant_id), 2);
    repeat (5) begin
      tick();
      check("t3_hold_valid", int'(bus.grant_valid), 1);
      check("t3_hold_id", int'(bus.grant_id), 2);
    end
    check("t3_pending_held", int'(pending[2]), 1);
    bus.grant_ready = 1'b1;
    tick();
    check("t3_pending_clr", int'(pending[2]), 0);
    check("t3_valid_drop", int'(bus.grant_valid), 0);
    check("t3_ngrants", grants.size(), 1);
    check("t3_gid", gnt(0), 2);
    key_in = '0;
    tick();
    tick();

    // 4: re-press of key 1 while still pending -> one dropped pulse
    bus.grant_ready = 1'b0;
    grants.delete();
    drop_cnt = 0;
    key_in = 4'b0010;
    tick();
    key_in = 4'b0000;
    tick();
    check("t4_valid", int'(bus.grant_valid), 1);
    check("t4_id", int'(bus.grant_id), 1);
    key_in = 4'b0010;
    tick();
    check("t4_dropped_on", int'(dropped), 1);
    tick();
    check("t4_dropped_off", int'(dropped), 0);
    bus.grant_ready = 1'b1;
    tick();
    check("t4_pending_clr", int'(pending), 0);
    repeat (4) tick();
    check("t4_ngrants", grants.size(), 1);
    check("t4_gid", gnt(0), 1);
    check("t4_drop_cnt", drop_cnt, 1);
    key_in = '0;
    tick();
    tick();

    // 5: key 3 re-edge on its own handshake cycle -> second grant
    bus.grant_ready = 1'b1;
    grants.delete();
    drop_cnt = 0;
    key_in = 4'b1000;
    tick();
    key_in = 4'b0000;
    tick();
    check("t5_valid", int'(bus.grant_valid), 1);
    check("t5_id", int'(bus.grant_id), 3);
    key_in = 4'b1000;
    tick();
    check("t5_pending_kept", int'(pending), 8);
    check("t5_valid_drop", int'(bus.grant_valid), 0);
    check("t5_no_drop", int'(dropped), 0);
    repeat (4) tick();
    check("t5_ngrants", grants.size(), 2);
    check("t5_gid0", gnt(0), 3);
    check("t5_gid1", gnt(1), 3);
    check("t5_pending_end", int'(pending), 0);
    check("t5_drop_cnt", drop_cnt, 0);
    key_in = '0;
    tick();
    tick();

    // 6: reset during an offer of id 1 with pending 1010
    bus.grant_ready = 1'b0;
    grants.delete();
    key_in = 4'b1010;
    tick();
    tick();
    check("t6_valid", int'(bus.grant_valid), 1);
    check("t6_id", int'(bus.grant_id), 1);
    check("t6_pending", int'(pending), 10);
    reset = 1'b0;
    tick();
    check("t6_rst_valid", int'(bus.grant_valid), 0);
    check("t6_rst_pending", int'(pending), 0);
    check("t6_rst_last", int'(dut.last), 3);
    reset           = 1'b1;
    bus.grant_ready = 1'b1;
    tick();
    check("t6_rereq", int'(pending), 10);
    tick();
    check("t6_scan_valid", int'(bus.grant_valid), 1);
    check("t6_scan_id", int'(bus.grant_id), 1);
    repeat (6) tick();
    check("t6_ngrants", grants.size(), 2);
    check("t6_gid0", gnt(0), 1);
    check("t6_gid1", gnt(1), 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
